// File: rtl/salu_rr_arbiter.sv
// ============================================================================
// Module   : salu_rr_arbiter (+ simple_alu)
// Brief    : Round-robin sharing of one registered ADD/SUB ALU between two
//            valid/ready requesters, one operation in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_alu #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_out,
  output logic             o_overflow,
  output logic             o_underflow
);

  assign o_out       = i_sel ? (i_a - i_b) : (i_a + i_b);
  // Flags look only at the operand MSBs, not at the result.
  assign o_overflow  = ~i_sel & ~i_a[WIDTH-1] & ~i_b[WIDTH-1];
  assign o_underflow =  i_sel &  i_a[WIDTH-1] &  i_b[WIDTH-1];

endmodule

module salu_rr_arbiter #(
  parameter  int WIDTH    = 2,
  localparam int c_NREQ   = 2,
  localparam int c_SWIDTH = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [c_NREQ-1:0]          i_req_valid,
  output logic [c_NREQ-1:0]          o_req_ready,
  input  logic [c_NREQ*WIDTH-1:0]    i_req_a,
  input  logic [c_NREQ*WIDTH-1:0]    i_req_b,
  input  logic [c_NREQ*c_SWIDTH-1:0] i_req_sel,
  output logic [c_NREQ-1:0]          o_resp_valid,
  input  logic [c_NREQ-1:0]          i_resp_ready,
  output logic [WIDTH-1:0]           o_resp_data,
  output logic                       o_resp_ovf,
  output logic                       o_resp_unf,
  output logic                       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_gnt;
  logic                  r_prio;
  logic [WIDTH-1:0]      r_op_a;
  logic [WIDTH-1:0]      r_op_b;
  logic [c_SWIDTH-1:0]   r_op_sel;
  logic [WIDTH-1:0]      r_res;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_any_valid;
  logic                  w_win;
  logic [WIDTH-1:0]      w_win_a;
  logic [WIDTH-1:0]      w_win_b;
  logic [c_SWIDTH-1:0]   w_win_sel;
  logic [WIDTH-1:0]      w_alu_out;
  logic                  w_alu_ovf;
  logic                  w_alu_unf;

  // Preferred requester wins if it asks, otherwise the other one.
  assign w_any_valid = |i_req_valid;
  assign w_win       = i_req_valid[r_prio] ? r_prio : ~r_prio;
  assign w_win_a     = w_win ? i_req_a[2*WIDTH-1:WIDTH] : i_req_a[WIDTH-1:0];
  assign w_win_b     = w_win ? i_req_b[2*WIDTH-1:WIDTH] : i_req_b[WIDTH-1:0];
  assign w_win_sel   = w_win ? i_req_sel[1] : i_req_sel[0];

  assign o_req_ready  = (i_reset_n && (r_state == S_IDLE) && w_any_valid)
                        ? {w_win, ~w_win} : '0;
  assign o_resp_valid = (r_state == S_RESP) ? {r_gnt, ~r_gnt} : '0;
  assign o_resp_data  = r_res;
  assign o_resp_ovf   = r_ovf;
  assign o_resp_unf   = r_unf;
  assign o_busy       = (r_state != S_IDLE);

  simple_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a         (r_op_a),
    .i_b         (r_op_b),
    .i_sel       (r_op_sel[0]),
    .o_out       (w_alu_out),
    .o_overflow  (w_alu_ovf),
    .o_underflow (w_alu_unf)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= 1'b0;
      r_prio   <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_sel <= '0;
      r_res    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_op_a   <= w_win_a;
            r_op_b   <= w_win_b;
            r_op_sel <= w_win_sel;
            r_gnt    <= w_win;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= w_alu_out;
          r_ovf   <= w_alu_ovf;
          r_unf   <= w_alu_unf;
          r_state <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's accept matters; the other bit is ignored.
          if (i_resp_ready[r_gnt]) begin
            r_prio  <= ~r_gnt;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_salu_rr_arbiter.sv
// ============================================================================
// Module   : tb_salu_rr_arbiter
// Brief    : Directed, table-driven self-checking bench for salu_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_salu_rr_arbiter;

  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_sel;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready;
  logic [3:0] resp_data;
  logic       resp_ovf;
  logic       resp_unf;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  salu_rr_arbiter #(
    .WIDTH (WIDTH)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_sel    (req_sel),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_data  (resp_data),
    .o_resp_ovf   (resp_ovf),
    .o_resp_unf   (resp_unf),
    .o_busy       (busy)
  );

  typedef struct {
    logic       rn;
    logic [1:0] v;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
    logic [1:0] rr;
    logic [1:0] e_rdy;
    logic [1:0] e_rv;
    logic       e_busy;
    logic       chk_res;
    logic [3:0] e_data;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic [1:0] rdy, input logic [1:0] rv,
                            input logic bsy);
    check({tag, ".req_ready"},  32'(req_ready),  32'(rdy));
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'(rv));
    check({tag, ".busy"},       32'(busy),       32'(bsy));
  endtask

  task automatic expect_resp(input string tag, input logic [3:0] d, input logic o, input logic u);
    check({tag, ".data"}, 32'(resp_data), 32'(d));
    check({tag, ".ovf"},  32'(resp_ovf),  32'(o));
    check({tag, ".unf"},  32'(resp_unf),  32'(u));
  endtask

  task automatic drive(input logic rn, input logic [1:0] v, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] sel, input logic [1:0] rr);
    reset_n    = rn;
    req_valid  = v;
    req_a      = a;
    req_b      = b;
    req_sel    = sel;
    resp_ready = rr;
  endtask

  // Advance to just after the next rising edge; checks happen #2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rn  v      a      b      sel    rr      rdy    rv     bsy  chk  data  ovf   unf
    // Single ADD from req0 after reset: 3+4=7, ovf from both MSBs clear.
    vecs.push_back('{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 8'h03, 8'h04, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 8'h03, 8'h04, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h03, 8'h04, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h03, 8'h04, 2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    // Reset then simultaneous requests: req0 5-2 SUB first, then req1 1+1 ADD.
    vecs.push_back('{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 8'h15, 8'h12, 2'b01, 2'b11, 2'b01, 2'b00, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 8'h15, 8'h12, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 8'h15, 8'h12, 2'b01, 2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 8'h15, 8'h12, 2'b01, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h15, 8'h12, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h15, 8'h12, 2'b01, 2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    // Wrap-around: 9+9=2, 2-5=0xD, 0xC-0xA=2 with unf.
    vecs.push_back('{1'b1, 2'b01, 8'h09, 8'h09, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 8'h02, 8'h05, 2'b01, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 4'hD, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 8'h0C, 8'h0A, 2'b01, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});

    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    tick();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].rr);
      #2;
      expect_ctl($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_rv, vecs[i].e_busy);
      if (vecs[i].chk_res)
        expect_resp($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_ovf, vecs[i].e_unf);
      tick();
    end

    // Response backpressure: req0 6-1 SUB held 5 cycles, req1 7+7 ADD waits.
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    tick();
    drive(1'b1, 2'b11, 8'h76, 8'h71, 2'b01, 2'b00);
    #2; expect_ctl("bp.grant0", 2'b01, 2'b00, 1'b0);
    tick();
    req_valid = 2'b10;
    #2; expect_ctl("bp.exec", 2'b00, 2'b00, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      #2;
      expect_ctl($sformatf("bp.hold%0d", i), 2'b00, 2'b01, 1'b1);
      expect_resp($sformatf("bp.hold%0d", i), 4'h5, 1'b0, 1'b0);
      tick();
    end
    resp_ready = 2'b01;
    #2; expect_ctl("bp.accept", 2'b00, 2'b01, 1'b1);
    tick();
    resp_ready = 2'b00;
    #2; expect_ctl("bp.grant1", 2'b10, 2'b00, 1'b0);
    tick();
    req_valid = 2'b00;
    #2; expect_ctl("bp.exec1", 2'b00, 2'b00, 1'b1);
    tick();
    resp_ready = 2'b10;
    #2; expect_ctl("bp.resp1", 2'b00, 2'b10, 1'b1);
    expect_resp("bp.resp1", 4'hE, 1'b1, 1'b0);
    tick();
    resp_ready = 2'b00;
    #2; expect_ctl("bp.idle", 2'b00, 2'b00, 1'b0);

    // Reset in EXEC drops the op.
    drive(1'b1, 2'b01, 8'h01, 8'h02, 2'b00, 2'b00);
    #2; expect_ctl("rst.grant", 2'b01, 2'b00, 1'b0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    #2; expect_ctl("rst.inexec", 2'b00, 2'b00, 1'b1);
    tick();
    reset_n = 1'b1;
    #2; expect_ctl("rst.afterexec", 2'b00, 2'b00, 1'b0);
    expect_resp("rst.afterexec", 4'h0, 1'b0, 1'b0);
    tick();
    // Complete a req0 op so prio points at req1 before the RESP reset.
    drive(1'b1, 2'b01, 8'h03, 8'h03, 2'b00, 2'b01);
    #2; expect_ctl("rst.op0", 2'b01, 2'b00, 1'b0);
    tick();
    req_valid = 2'b00;
    tick();
    #2; expect_resp("rst.op0", 4'h6, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'b10, 8'h20, 8'h10, 2'b00, 2'b00);
    #2; expect_ctl("rst.op1", 2'b10, 2'b00, 1'b0);
    tick();
    req_valid = 2'b00;
    tick();
    #2; expect_ctl("rst.inresp", 2'b00, 2'b10, 1'b1);
    expect_resp("rst.inresp", 4'h3, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1; check("rst.ready_low", 32'(req_ready), 32'(2'b00));
    tick();
    drive(1'b1, 2'b11, 8'h44, 8'h11, 2'b00, 2'b00);
    #2; expect_ctl("rst.afterresp", 2'b01, 2'b00, 1'b0);
    expect_resp("rst.afterresp", 4'h0, 1'b0, 1'b0);
    tick();
    req_valid = 2'b10;
    resp_ready = 2'b11;
    #2; expect_ctl("rst.exec", 2'b00, 2'b00, 1'b1);
    tick();
    #2; expect_ctl("rst.resp0", 2'b00, 2'b01, 1'b1);
    expect_resp("rst.resp0", 4'h5, 1'b1, 1'b0);
    tick();
    #2; expect_ctl("rst.grant1", 2'b10, 2'b00, 1'b0);
    tick();
    req_valid = 2'b00;
    tick();
    #2; expect_ctl("rst.resp1", 2'b00, 2'b10, 1'b1);
    expect_resp("rst.resp1", 4'h5, 1'b1, 1'b0);
    tick();

    // Req0 alone, four back-to-back ops (k+1)+k; non-owner accept ignored.
    drive(1'b1, 2'b01, 8'h01, 8'h00, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) begin
      #2; expect_ctl($sformatf("b2b%0d.grant", k), 2'b01, 2'b00, 1'b0);
      tick();
      req_valid  = (k < 3) ? 2'b01 : 2'b00;
      req_a      = {4'h0, 4'(k + 2)};
      req_b      = {4'h0, 4'(k + 1)};
      resp_ready = 2'b10;
      #2; expect_ctl($sformatf("b2b%0d.exec", k), 2'b00, 2'b00, 1'b1);
      tick();
      if (k == 0) begin
        #2; expect_ctl("b2b0.nonowner", 2'b00, 2'b01, 1'b1);
        tick();
      end
      resp_ready = 2'b11;
      #2; expect_ctl($sformatf("b2b%0d.resp", k), 2'b00, 2'b01, 1'b1);
      expect_resp($sformatf("b2b%0d.resp", k), 4'(2 * k + 1), 1'b1, 1'b0);
      tick();
      resp_ready = 2'b00;
    end
    #2; expect_ctl("b2b.idle", 2'b00, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
